soc_mode_ctrl: RTL and testbench

- Synchronises and debounces the external programmer-mode pin.
- Sequences core/programmer resets through a drain-and-hold state machine.
- Routes N UART channels and the QSPI pad group between the core and the UART programmer without glitches.
- Sits between board pads and `soc_top`, replacing ad-hoc combinational mode muxing in FPGA and ASIC wrappers.

---
 rtl/soc_mode_pkg.sv | 23 ++
 rtl/soc_mode_debounce.sv | 49 ++++
 rtl/soc_mode_ctrl.sv | 168 ++++++++++++++++
 tb/tb_soc_mode_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mode_pkg.sv
// Shared types and counter-width helper for the SoC mode controller.
package soc_mode_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_DRAIN = 2'd2,
        MODE_PROG  = 2'd3
    } mode_state_e;

    // Counters only ever hold values up to (count - 1), so clog2 of the largest count suffices.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(1024, 16, 4096);

endpackage

// File: rtl/soc_mode_debounce.sv
// Mode-pin synchroniser and debounce counter; dbm_o toggles after the synchronised
// pin has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module soc_mode_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned CNT_W           = soc_mode_pkg::CNT_W_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic dbm_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dbm_q, dbm_d;
    logic                   pin_sync;

    assign pin_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d = '0;
        dbm_d = dbm_q;
        if (pin_sync != dbm_q) begin
            if (cnt_q == CNT_LAST) begin
                dbm_d = ~dbm_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dbm_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q  <= cnt_d;
            dbm_q  <= dbm_d;
        end
    end

    assign dbm_o = dbm_q;

endmodule

// File: rtl/soc_mode_ctrl.sv
// Programmer-mode sequencer: drain/hold reset FSM plus glitch-free UART/QSPI pad routing.
// Build option SOC_MODE_QSPI_TIE_EN ties QSPI inputs off for bring-up without flash.
//
// state | meaning
// HOLD  | core and programmer in reset for RESET_HOLD_CYCLES, pads parked
// RUN   | core owns all UART and QSPI pads
// DRAIN | core still running, RX gated, waiting for core TX to go idle
// PROG  | core in reset, programmer owns UART channel PROG_CH
module soc_mode_ctrl
    import soc_mode_pkg::*;
#(
    parameter int unsigned UART_CH           = 1,
    parameter int unsigned PROG_CH           = 0,
    parameter int unsigned QSPI_LANES        = 4,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 1024,
    parameter int unsigned RESET_HOLD_CYCLES = 16,
    parameter int unsigned DRAIN_TIMEOUT     = 4096
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  prog_mode_i,
    input  logic [UART_CH-1:0]    uart_rx_pad_i,
    output logic [UART_CH-1:0]    uart_tx_pad_o,
    output logic [UART_CH-1:0]    core_uart_rx_o,
    input  logic [UART_CH-1:0]    core_uart_tx_i,
    input  logic [UART_CH-1:0]    core_uart_busy_i,
    output logic                  prog_uart_rx_o,
    input  logic                  prog_uart_tx_i,
    output logic                  core_reset_o,
    output logic                  prog_reset_o,
    output logic                  prog_enable_o,
    output logic [1:0]            mode_o,
    input  logic                  core_qspi_sclk_i,
    input  logic                  core_qspi_cs_n_i,
    output logic                  pad_qspi_sclk_o,
    output logic                  pad_qspi_cs_n_o,
    input  logic [QSPI_LANES-1:0] core_qspi_do_i,
    input  logic [QSPI_LANES-1:0] core_qspi_oen_i,
    output logic [QSPI_LANES-1:0] pad_qspi_do_o,
    output logic [QSPI_LANES-1:0] pad_qspi_oen_o,
    input  logic [QSPI_LANES-1:0] pad_qspi_di_i,
    output logic [QSPI_LANES-1:0] core_qspi_di_o
);

    localparam int unsigned      CNT_W      = cnt_width(DEBOUNCE_CYCLES, RESET_HOLD_CYCLES,
                                                        DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 1);

    mode_state_e      state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             core_reset_q, prog_reset_q, prog_enable_q;
    logic             dbm;
    logic             qspi_pass;

    soc_mode_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .pin_i  (prog_mode_i),
        .dbm_o  (dbm)
    );

    // One shared down-counter times both the reset hold and the drain timeout.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            MODE_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = dbm ? MODE_PROG : MODE_RUN;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            MODE_RUN: begin
                if (dbm) begin
                    state_d = MODE_DRAIN;
                    tmr_d   = DRAIN_LOAD;
                end
            end
            MODE_DRAIN: begin
                if (!dbm) begin
                    state_d = MODE_RUN;
                end else if (core_uart_busy_i == '0 || tmr_q == '0) begin
                    state_d = MODE_PROG;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            MODE_PROG: begin
                if (!dbm) begin
                    state_d = MODE_HOLD;
                    tmr_d   = HOLD_LOAD;
                end
            end
            default: begin
                state_d = MODE_HOLD;
                tmr_d   = HOLD_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= MODE_HOLD;
            tmr_q         <= HOLD_LOAD;
            core_reset_q  <= 1'b1;
            prog_reset_q  <= 1'b1;
            prog_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            core_reset_q  <= (state_d == MODE_HOLD) || (state_d == MODE_PROG);
            prog_reset_q  <= (state_d != MODE_PROG);
            prog_enable_q <= (state_d == MODE_PROG);
        end
    end

    assign core_reset_o  = core_reset_q;
    assign prog_reset_o  = prog_reset_q;
    assign prog_enable_o = prog_enable_q;
    assign mode_o        = state_q;

    // Pad routing decodes only the state register, never the raw or debounced pin.
    always_comb begin
        uart_tx_pad_o  = '1;
        core_uart_rx_o = '1;
        prog_uart_rx_o = 1'b1;
        unique case (state_q)
            MODE_RUN: begin
                uart_tx_pad_o  = core_uart_tx_i;
                core_uart_rx_o = uart_rx_pad_i;
                prog_uart_rx_o = uart_rx_pad_i[PROG_CH];
            end
            MODE_DRAIN: begin
                uart_tx_pad_o = core_uart_tx_i;
            end
            MODE_PROG: begin
                uart_tx_pad_o[PROG_CH] = prog_uart_tx_i;
                prog_uart_rx_o         = uart_rx_pad_i[PROG_CH];
            end
            default: begin
                uart_tx_pad_o = '1;
            end
        endcase
    end

    assign qspi_pass = (state_q == MODE_RUN) || (state_q == MODE_DRAIN);

    always_comb begin
        pad_qspi_sclk_o = qspi_pass ? core_qspi_sclk_i : 1'b0;
        pad_qspi_cs_n_o = qspi_pass ? core_qspi_cs_n_i : 1'b1;
        pad_qspi_do_o   = qspi_pass ? core_qspi_do_i : '0;
`ifdef SOC_MODE_QSPI_TIE_EN
        pad_qspi_oen_o  = '1;
        core_qspi_di_o  = '0;
`else
        pad_qspi_oen_o  = qspi_pass ? core_qspi_oen_i : '1;
        core_qspi_di_o  = qspi_pass ? pad_qspi_di_i : '0;
`endif
    end

endmodule

// File: tb/tb_soc_mode_ctrl.sv
// Directed bench for soc_mode_ctrl with an in-order expected-value scoreboard.
module tb_soc_mode_ctrl;

    localparam int unsigned UART_CH    = 2;
    localparam int unsigned PROG_CH    = 1;
    localparam int unsigned QSPI_LANES = 4;

`ifdef SOC_MODE_QSPI_TIE_EN
    localparam logic [3:0] RUN_OEN = 4'hF;
    localparam logic [3:0] RUN_DI  = 4'h0;
`else
    localparam logic [3:0] RUN_OEN = 4'h3;
    localparam logic [3:0] RUN_DI  = 4'h5;
`endif

    logic                  clk, reset, prog_mode;
    logic [UART_CH-1:0]    uart_rx_pad, uart_tx_pad, core_uart_rx, core_uart_tx, core_uart_busy;
    logic                  prog_uart_rx, prog_uart_tx;
    logic                  core_reset, prog_reset, prog_enable;
    logic [1:0]            mode;
    logic                  core_sclk, core_cs_n, pad_sclk, pad_cs_n;
    logic [QSPI_LANES-1:0] core_do, core_oen, pad_do, pad_oen, pad_di, core_di;

    soc_mode_ctrl #(
        .UART_CH          (UART_CH),
        .PROG_CH          (PROG_CH),
        .QSPI_LANES       (QSPI_LANES),
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (8),
        .RESET_HOLD_CYCLES(4),
        .DRAIN_TIMEOUT    (20)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .prog_mode_i     (prog_mode),
        .uart_rx_pad_i   (uart_rx_pad),
        .uart_tx_pad_o   (uart_tx_pad),
        .core_uart_rx_o  (core_uart_rx),
        .core_uart_tx_i  (core_uart_tx),
        .core_uart_busy_i(core_uart_busy),
        .prog_uart_rx_o  (prog_uart_rx),
        .prog_uart_tx_i  (prog_uart_tx),
        .core_reset_o    (core_reset),
        .prog_reset_o    (prog_reset),
        .prog_enable_o   (prog_enable),
        .mode_o          (mode),
        .core_qspi_sclk_i(core_sclk),
        .core_qspi_cs_n_i(core_cs_n),
        .pad_qspi_sclk_o (pad_sclk),
        .pad_qspi_cs_n_o (pad_cs_n),
        .core_qspi_do_i  (core_do),
        .core_qspi_oen_i (core_oen),
        .pad_qspi_do_o   (pad_do),
        .pad_qspi_oen_o  (pad_oen),
        .pad_qspi_di_i   (pad_di),
        .core_qspi_di_o  (core_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=%0h", obs);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        prog_mode      = 1'b0;
        uart_rx_pad    = 2'b11;
        core_uart_tx   = 2'b00;
        core_uart_busy = 2'b00;
        prog_uart_tx   = 1'b1;
        core_sclk      = 1'b1;
        core_cs_n      = 1'b0;
        core_do        = 4'hA;
        core_oen       = 4'h3;
        pad_di         = 4'h5;

        // Reset values and parked pads
        push("rst_mode", 0); push("rst_core_reset", 1); push("rst_prog_reset", 1);
        push("rst_prog_en", 0); push("rst_tx_pad", 2'b11); push("rst_qspi_oen", 4'hF);
        push("rst_qspi_cs_n", 1); push("rst_qspi_sclk", 0); push("rst_core_di", 0);
        step(3);
        chk(mode); chk(core_reset); chk(prog_reset); chk(prog_enable); chk(uart_tx_pad);
        chk(pad_oen); chk(pad_cs_n); chk(pad_sclk); chk(core_di);

        // HOLD lasts exactly four cycles after reset release
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push("hold_mode", 0);
            chk(mode);
            step(1);
        end

        // RUN: full pass-through
        uart_rx_pad  = 2'b10;
        core_uart_tx = 2'b01;
        push("run_mode", 1); push("run_core_reset", 0); push("run_prog_reset", 1);
        push("run_core_rx", 2'b10); push("run_tx_pad", 2'b01); push("run_prog_rx", 1);
        push("run_qspi_do", 4'hA); push("run_qspi_oen", RUN_OEN); push("run_core_di", RUN_DI);
        push("run_qspi_sclk", 1); push("run_qspi_cs_n", 0);
        #1;
        chk(mode); chk(core_reset); chk(prog_reset); chk(core_uart_rx); chk(uart_tx_pad);
        chk(prog_uart_rx); chk(pad_do); chk(pad_oen); chk(core_di); chk(pad_sclk); chk(pad_cs_n);

        // Clean pin rise, core idle: dbm after 2+8 edges, DRAIN one edge later, then PROG
        prog_mode   = 1'b1;
        uart_rx_pad = 2'b00;
        push("dbm_before", 0);
        step(9);
        chk(dbm_of());
        push("dbm_after", 1); push("mode_at_dbm", 1);
        step(1);
        chk(dbm_of()); chk(mode);
        push("drain_mode", 2); push("drain_core_rx", 2'b11); push("drain_tx_pad", 2'b01);
        push("drain_prog_rx", 1); push("drain_core_reset", 0); push("drain_qspi_oen", RUN_OEN);
        step(1);
        chk(mode); chk(core_uart_rx); chk(uart_tx_pad); chk(prog_uart_rx); chk(core_reset);
        chk(pad_oen);
        push("prog_mode", 3); push("prog_en", 1); push("prog_core_reset", 1);
        push("prog_prog_reset", 0);
        step(1);
        chk(mode); chk(prog_enable); chk(core_reset); chk(prog_reset);

        uart_rx_pad  = 2'b10;
        prog_uart_tx = 1'b0;
        push("prog_rx_hi", 1); push("prog_core_rx", 2'b11); push("prog_tx_pad", 2'b01);
        push("prog_qspi_oen", 4'hF); push("prog_qspi_cs_n", 1); push("prog_qspi_sclk", 0);
        push("prog_core_di", 0);
        #1;
        chk(prog_uart_rx); chk(core_uart_rx); chk(uart_tx_pad); chk(pad_oen); chk(pad_cs_n);
        chk(pad_sclk); chk(core_di);
        uart_rx_pad = 2'b01;
        push("prog_rx_lo", 0);
        #1;
        chk(prog_uart_rx);
        prog_uart_tx = 1'b1;

        // Pin low in PROG: HOLD for four cycles with both resets, then RUN
        prog_mode = 1'b0;
        push("prog_before_fall", 3);
        step(10);
        chk(mode);
        push("hold2_mode", 0); push("hold2_core_reset", 1); push("hold2_prog_reset", 1);
        push("hold2_prog_en", 0); push("hold2_tx_pad", 2'b11);
        step(1);
        chk(mode); chk(core_reset); chk(prog_reset); chk(prog_enable); chk(uart_tx_pad);
        for (int i = 0; i < 3; i++) begin
            push("hold2_cycle", 0);
            step(1);
            chk(mode);
        end
        push("hold2_exit", 1);
        step(1);
        chk(mode);

        // Busy core: DRAIN times out after exactly 20 cycles
        core_uart_busy = 2'b01;
        prog_mode      = 1'b1;
        push("busy_drain_entry", 2);
        step(11);
        chk(mode);
        push("busy_drain_last", 2);
        step(19);
        chk(mode);
        push("busy_timeout_prog", 3);
        step(1);
        chk(mode);
        prog_mode = 1'b0;
        push("busy_hold", 0);
        step(11);
        chk(mode);
        push("busy_run", 1);
        step(4);
        chk(mode);

        // dbm falls on the same edge the drain timeout expires: RUN wins
        core_uart_busy = 2'b11;
        prog_mode      = 1'b1;
        push("race_drain", 2);
        step(11);
        chk(mode);
        step(9);
        prog_mode = 1'b0;
        push("race_still_drain", 2); push("race_dbm_low", 0);
        step(10);
        chk(mode); chk(dbm_of());
        push("race_run_wins", 1);
        step(1);
        chk(mode);

        // Five-cycle glitch is rejected and the counter recovers to zero
        prog_mode = 1'b1;
        push("glitch_cnt_mid", 3);
        step(5);
        chk(cnt_of());
        prog_mode = 1'b0;
        push("glitch_mode", 1); push("glitch_dbm", 0); push("glitch_cnt", 0);
        step(10);
        chk(mode); chk(dbm_of()); chk(cnt_of());

        // Reset in the middle of DRAIN
        prog_mode = 1'b1;
        push("rst_drain_entry", 2);
        step(11);
        chk(mode);
        step(5);
        reset = 1'b1;
        push("rstd_mode", 0); push("rstd_prog_reset", 1); push("rstd_core_reset", 1);
        push("rstd_prog_en", 0); push("rstd_dbm", 0); push("rstd_cnt", 0);
        step(1);
        chk(mode); chk(prog_reset); chk(core_reset); chk(prog_enable); chk(dbm_of()); chk(cnt_of());
        prog_mode = 1'b0;
        step(2);
        reset = 1'b0;
        push("rstd_run", 1);
        step(4);
        chk(mode);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [31:0] dbm_of();
        return 32'(dut.u_debounce.dbm_q);
    endfunction

    function automatic logic [31:0] cnt_of();
        return 32'(dut.u_debounce.cnt_q);
    endfunction

endmodule
